// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loaded N-bit pattern, overlap/non-overlap modes,
// bit-valid qualifier and a saturating match counter. z is registered (no x->z comb path).
module seq_detector_param #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [FW-1:0]    FILL_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    logic [N-1:0]  pat;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  nh;
    logic [FW-1:0] nf;
    logic          hit;

    // fill guards against false hits on the zero-filled history right after reset/load
    always_comb begin
        nh  = {hist[N-2:0], x};
        nf  = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
        hit = (nf == FILL_FULL) && (nh == pat);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat       <= '0;
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
        end else if (load) begin
            pat       <= pat_in;
            hist      <= '0;
            fill      <= '0;
            z         <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            hist <= nh;
            fill <= (hit && !overlap) ? '0 : nf;
            z    <= hit;
            if (hit && (match_cnt != CNT_MAX))
                match_cnt <= match_cnt + CNT_ONE;
        end else begin
            z <= 1'b0;
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the fixed-pattern serial sequence detector. It detects a runtime-programmable N-bit pattern on a serial input. It supports overlapping and non-overlapping detection modes, an enable input, and a saturating match counter. It sits on a serial bit stream (one bit per clk) and flags each pattern occurrence to downstream control logic.

Parameters:
N, 4, pattern length in bits (N >= 2)
CNT_W, 8, width of saturating match counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
x  input  1  serial data bit, sampled on rising clk when en=1
en  input  1  bit-valid qualifier; en=0 holds all state, z driven 0
load  input  1  one-cycle strobe: capture pat_in, flush history
pat_in  input  N  pattern to detect; pat_in[N-1] is first bit in time, pat_in[0] is last
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
z  output  1  registered match pulse, high for exactly one cycle per match
match_cnt  output  CNT_W  number of matches since reset/load, saturating

Behaviour:
- Reset (async, reset=1): pat <= 0, hist <= 0, fill <= 0, z <= 0, match_cnt <= 0. Outputs hold these values for as long as reset is high. Release takes effect on the first following rising edge.
- Internal state:
  - pat: N-bit pattern register.
  - hist: N-bit shift register; newest bit is at LSB.
  - fill: counter 0..N giving the number of valid bits in hist.
- Priority per edge, highest first: reset > load > en.
- load=1: pat <= pat_in, hist <= 0, fill <= 0, z <= 0, match_cnt <= 0. x is ignored that cycle, even if en=1.
- en=1, load=0:
  - nh = {hist[N-2:0], x}; nf = min(fill+1, N).
  - hit = (nf == N) && (nh == pat).
  - hist <= nh.
  - fill <= (hit && !overlap) ? 0 : nf.
  - z <= hit.
  - If hit and match_cnt != all-ones: match_cnt <= match_cnt + 1.
- en=0, load=0: hist, fill and match_cnt hold; z <= 0.
- Latency: z rises on the same edge that samples the final pattern bit. It is visible for the following clk cycle. No combinational path from x to z.
- No match is possible until N valid bits have been received since reset/load. This prevents false hits on the zero-filled history, e.g. pattern 0000.
- Overlap mode: the trailing bits of one match can start the next match. For pattern 1111 with continuous ones, z is high on every cycle from the 4th bit onward.
- Non-overlap mode: after a hit, the next match needs N fresh bits.
- Changing overlap mid-stream takes effect on the next sampled bit. Earlier history is not retroactively changed.
- match_cnt saturates at 2^CNT_W-1 and does not wrap. z still pulses on hits while saturated.
- en gaps do not break a sequence: bits are contiguous in en=1 cycles only.
- Reset mid-sequence discards the partial match. The pattern returns to 0, so software must issue load after reset.

Test Plan:
1. N=4; load pat_in=0110, overlap=1, en=1. Stream 0,0,1,1,0,1,1,0,0,1,1,0 → z high after bits 5, 8 and 12; match_cnt=3.
2. Same stream with overlap=0 → z high after bits 5 and 12 only; match_cnt=2.
3. pat=1111, seven consecutive 1s:
   - overlap=1 → z high after bits 4,5,6,7; match_cnt=4.
   - overlap=0 → z high after bit 4 only; match_cnt=1.
4. pat=0000, load then three 0s → z stays 0 (fill<4); fourth 0 → z=1.
5. CNT_W=2, pat=1111, overlap=1, nine 1s → match_cnt goes 1,2,3 then stays 3; z keeps pulsing.
6. Enable and restart cases, pat=0110, overlap=1:
   - en=0 for 3 cycles between bits 2 and 3 of 0110 → match still detected; z=0 during the gap.
   - Assert reset asynchronously mid-sequence → z and match_cnt go to 0 immediately.
   - Reload 0110, then stream 0,1,1,0 → match after bit 4.
